// File: rtl/uart_rx_fifo_if.sv
// Host-side bundle of the UART receiver: serial line in, FIFO read port and
// status out. The receiver takes the slave view, its user the master view.
interface uart_rx_fifo_if #(
    parameter int unsigned BUFFER_SIZE = 32
);
    localparam int unsigned CNT_W = $clog2(BUFFER_SIZE) + 1;

    logic             rx;
    logic             rd_en;
    logic             clear_err;
    logic [7:0]       rd_data;
    logic             rx_empty;
    logic             rx_full;
    logic [CNT_W-1:0] rx_count;
    logic             frame_err;
    logic             overrun;

    modport master (
        output rx, rd_en, clear_err,
        input  rd_data, rx_empty, rx_full, rx_count, frame_err, overrun
    );

    modport slave (
        input  rx, rd_en, clear_err,
        output rd_data, rx_empty, rx_full, rx_count, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a first-word fall-through
// byte FIFO, with sticky framing-error and overrun flags.
module uart_rx_fifo #(
    parameter int unsigned CLOCK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned BUFFER_SIZE = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_rx_fifo_if.slave bus
);
    localparam int unsigned DIV   = CLOCK_FREQ / (BAUD_RATE * 16);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PTR_W = $clog2(BUFFER_SIZE);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e           state_q, state_d;
    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       tc_q, tc_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tick_c, push_req_c, ferr_set_c;

    logic [7:0]       mem_q [BUFFER_SIZE];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             empty_q, empty_d, full_q, full_d;
    logic             ferr_q, ferr_d, ovr_q, ovr_d;
    logic             push_c, pop_c, ovr_set_c;

    wire rx_sync = rx_s2_q;

    // Divider runs only while a frame is in progress.
    assign tick_c = (state_q != IDLE) && (div_q == DIV_W'(DIV - 1));

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        tc_d       = tc_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        push_req_c = 1'b0;
        ferr_set_c = 1'b0;

        if (state_q != IDLE) begin
            if (tick_c) begin
                div_d = '0;
                tc_d  = tc_q + 4'd1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end

        unique case (state_q)
            IDLE: begin
                // Falling edge only, so a low line after a bad stop bit cannot re-trigger.
                if (rx_prev_q && !rx_sync) begin
                    state_d = START;
                    div_d   = '0;
                    tc_d    = '0;
                end
            end
            START: begin
                if (tick_c && tc_q == 4'd7) begin
                    if (!rx_sync) begin
                        state_d   = DATA;
                        tc_d      = '0;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick_c && tc_q == 4'd15) begin
                    shift_d   = {rx_sync, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick_c && tc_q == 4'd15) begin
                    state_d = IDLE;
                    if (rx_sync) begin
                        push_req_c = 1'b1;
                    end else begin
                        ferr_set_c = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    always_comb begin
        pop_c     = bus.rd_en && !empty_q;
        push_c    = push_req_c && (!full_q || bus.rd_en);
        ovr_set_c = push_req_c && full_q && !bus.rd_en;

        rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        empty_d  = (count_d == '0);
        full_d   = (count_d == CNT_W'(BUFFER_SIZE));

        if (push_c && (wr_ptr_q == rd_ptr_d)) begin
            rd_data_d = shift_q;
        end else if (count_d == '0) begin
            rd_data_d = rd_data_q;
        end else begin
            rd_data_d = mem_q[rd_ptr_d];
        end

        ferr_d = ferr_set_c ? 1'b1 : (bus.clear_err ? 1'b0 : ferr_q);
        ovr_d  = ovr_set_c  ? 1'b1 : (bus.clear_err ? 1'b0 : ovr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            div_q     <= '0;
            tc_q      <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_s1_q   <= bus.rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_sync;
            state_q   <= state_d;
            div_q     <= div_d;
            tc_q      <= tc_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rx_empty  = empty_q;
    assign bus.rx_full   = full_q;
    assign bus.rx_count  = count_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
endmodule
